// File: rtl/uart_rx_cfg_if.sv
// Byte-level result bundle of the configurable UART receiver.
// The receiver drives it (master); the consumer samples it (slave).
`timescale 1ns/1ps
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 o_rx_dv;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_busy;

  modport master (
    output o_rx_dv, o_rx_data, o_parity_err, o_frame_err, o_break, o_busy
  );

  modport slave (
    input o_rx_dv, o_rx_data, o_parity_err, o_frame_err, o_break, o_busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// with parity/framing error reporting and break detection.
`timescale 1ns/1ps
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rx_serial,
  uart_rx_cfg_if.master rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // DATA_BITS >= 5 keeps this at least 3 bits, wide enough for the stop count too
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEANUP
  } state_t;

  state_t               state_reg, state_next;
  logic                 sync_reg, rxs_reg;
  logic [CNT_W-1:0]     clk_cnt_reg, clk_cnt_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] bit_sel;
  logic                 par_err_reg, par_err_next;
  logic                 par_bit_reg, par_bit_next;
  logic                 frm_err_reg, frm_err_next;
  logic                 rearm_reg, rearm_next;
  logic                 dv_reg, dv_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 perr_out_reg, perr_out_next;
  logic                 ferr_out_reg, ferr_out_next;
  logic                 brk_out_reg, brk_out_next;
  logic                 sample_tick;
  logic                 stop_err;

  // One-hot select of the data bit currently being sampled
  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_bit_sel
    assign bit_sel[gi] = (bit_cnt_reg == BIT_W'(gi));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_reg     <= 1'b1;
      rxs_reg      <= 1'b1;
      state_reg    <= S_IDLE;
      clk_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      par_err_reg  <= 1'b0;
      par_bit_reg  <= 1'b0;
      frm_err_reg  <= 1'b0;
      rearm_reg    <= 1'b1;
      dv_reg       <= 1'b0;
      data_reg     <= '0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
      brk_out_reg  <= 1'b0;
    end else begin
      sync_reg     <= i_rx_serial;
      rxs_reg      <= sync_reg;
      state_reg    <= state_next;
      clk_cnt_reg  <= clk_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      par_err_reg  <= par_err_next;
      par_bit_reg  <= par_bit_next;
      frm_err_reg  <= frm_err_next;
      rearm_reg    <= rearm_next;
      dv_reg       <= dv_next;
      data_reg     <= data_next;
      perr_out_reg <= perr_out_next;
      ferr_out_reg <= ferr_out_next;
      brk_out_reg  <= brk_out_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clk_cnt_next  = clk_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    par_err_next  = par_err_reg;
    par_bit_next  = par_bit_reg;
    frm_err_next  = frm_err_reg;
    dv_next       = 1'b0;
    data_next     = data_reg;
    perr_out_next = perr_out_reg;
    ferr_out_next = ferr_out_reg;
    brk_out_next  = brk_out_reg;
    sample_tick   = (clk_cnt_reg == LAST_CNT);
    stop_err      = frm_err_reg | ~rxs_reg;
    // A held-low line after a framing error must go high before a new start is accepted
    rearm_next    = rearm_reg | rxs_reg;

    case (state_reg)
      S_IDLE: begin
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        if (!rxs_reg && rearm_reg) state_next = S_START;
      end

      S_START: begin
        if (clk_cnt_reg == HALF_CNT) begin
          clk_cnt_next = '0;
          state_next   = rxs_reg ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (sample_tick) begin
          clk_cnt_next = '0;
          shift_next   = (shift_reg & ~bit_sel) | ({DATA_BITS{rxs_reg}} & bit_sel);
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
            state_next   = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (sample_tick) begin
          clk_cnt_next = '0;
          par_bit_next = rxs_reg;
          par_err_next = rxs_reg ^ (^shift_reg) ^ PAR_ODD;
          state_next   = S_STOP;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (sample_tick) begin
          clk_cnt_next = '0;
          if (bit_cnt_reg == LAST_STOP) begin
            bit_cnt_next  = '0;
            dv_next       = 1'b1;
            data_next     = shift_reg;
            perr_out_next = PAR_EN & par_err_reg;
            ferr_out_next = stop_err;
            brk_out_next  = stop_err & (shift_reg == '0) & ~(PAR_EN & par_bit_reg);
            if (stop_err) rearm_next = 1'b0;
            state_next    = S_CLEANUP;
          end else begin
            frm_err_next = stop_err;
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end

      S_CLEANUP: begin
        frm_err_next = 1'b0;
        par_err_next = 1'b0;
        par_bit_next = 1'b0;
        state_next   = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign rx_if.o_rx_dv      = dv_reg;
  assign rx_if.o_rx_data    = data_reg;
  assign rx_if.o_parity_err = perr_out_reg;
  assign rx_if.o_frame_err  = ferr_out_reg;
  assign rx_if.o_break      = brk_out_reg;
  assign rx_if.o_busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four receiver configurations fed from a bit-level
// frame generator, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int CPB = 16;
  // Per-instance configuration: 0=8N1, 1=8E1, 2=8N2, 3=7O1
  localparam int DB  [4] = '{8, 8, 8, 7};
  localparam int PEN [4] = '{0, 1, 0, 1};
  localparam int ODD [4] = '{0, 0, 0, 1};
  localparam int SB  [4] = '{1, 1, 2, 1};

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } rec_t;

  typedef struct packed {
    logic       dv;
    logic       busy;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] line;
  int         compared   = 0;
  int         mismatched = 0;
  rec_t       q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if3 ();

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u0 (.i_clk(clk), .i_rst(rst), .i_rx_serial(line[0]), .rx_if(if0));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u1 (.i_clk(clk), .i_rst(rst), .i_rx_serial(line[1]), .rx_if(if1));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u2 (.i_clk(clk), .i_rst(rst), .i_rx_serial(line[2]), .rx_if(if2));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u3 (.i_clk(clk), .i_rst(rst), .i_rx_serial(line[3]), .rx_if(if3));

  always @(negedge clk) begin
    if (if0.o_rx_dv === 1'b1)
      q0.push_back(rec_t'({9'(if0.o_rx_data), if0.o_parity_err, if0.o_frame_err, if0.o_break}));
    if (if1.o_rx_dv === 1'b1)
      q1.push_back(rec_t'({9'(if1.o_rx_data), if1.o_parity_err, if1.o_frame_err, if1.o_break}));
    if (if2.o_rx_dv === 1'b1)
      q2.push_back(rec_t'({9'(if2.o_rx_data), if2.o_parity_err, if2.o_frame_err, if2.o_break}));
    if (if3.o_rx_dv === 1'b1)
      q3.push_back(rec_t'({9'(if3.o_rx_data), if3.o_parity_err, if3.o_frame_err, if3.o_break}));
  end

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      3:       return q3.size();
      default: return 0;
    endcase
  endfunction

  function automatic rec_t pop_rec(input int k);
    rec_t r;
    r = '0;
    case (k)
      0:       r = q0.pop_front();
      1:       r = q1.pop_front();
      2:       r = q2.pop_front();
      3:       r = q3.pop_front();
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic snap_t snap(input int k);
    snap_t s;
    s = '0;
    case (k)
      0: s = {if0.o_rx_dv, if0.o_busy, 9'(if0.o_rx_data), if0.o_parity_err, if0.o_frame_err, if0.o_break};
      1: s = {if1.o_rx_dv, if1.o_busy, 9'(if1.o_rx_data), if1.o_parity_err, if1.o_frame_err, if1.o_break};
      2: s = {if2.o_rx_dv, if2.o_busy, 9'(if2.o_rx_data), if2.o_parity_err, if2.o_frame_err, if2.o_break};
      3: s = {if3.o_rx_dv, if3.o_busy, 9'(if3.o_rx_data), if3.o_parity_err, if3.o_frame_err, if3.o_break};
      default: s = '0;
    endcase
    return s;
  endfunction

  // Reference: what a correct receiver reports for a frame, from the frame contents alone
  function automatic rec_t model(input int k, input logic [8:0] data, input logic pbit,
                                 input logic [1:0] stops);
    rec_t       r;
    logic [8:0] d;
    d      = data & 9'((1 << DB[k]) - 1);
    r.data = d;
    r.perr = (PEN[k] != 0) && (pbit != ((^d) ^ (ODD[k] != 0)));
    r.ferr = (stops[0] == 1'b0) || (SB[k] == 2 && stops[1] == 1'b0);
    r.brk  = r.ferr && (d == 9'd0) && (PEN[k] == 0 || pbit == 1'b0);
    return r;
  endfunction

  function automatic logic good_parity(input int k, input logic [8:0] data);
    logic [8:0] d;
    d = data & 9'((1 << DB[k]) - 1);
    return (^d) ^ (ODD[k] != 0);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int k, input logic v);
    line[k] = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops);
    drive_bit(k, 1'b0);
    for (int i = 0; i < DB[k]; i++) drive_bit(k, data[i]);
    if (PEN[k] != 0) drive_bit(k, pbit);
    for (int i = 0; i < SB[k]; i++) drive_bit(k, stops[i]);
    line[k] = 1'b1;
  endtask

  task automatic test_reset;
    snap_t s;
    rst  = 1'b1;
    line = 4'hF;
    idle(3);
    rst = 1'b0;
    idle(4);
    for (int k = 0; k < 4; k++) begin
      s = snap(k);
      compared++;
      if (s !== '0) begin
        mismatched++;
        $display("FAIL reset_state[%0d]: got %h expected 0", k, s);
      end else $display("reset[%0d]: outputs idle", k);
    end
  endtask

  task automatic test_basic;
    bit   found;
    int   lat;
    rec_t r, e;
    found = 1'b0;
    lat   = 0;
    e     = model(0, 9'h0A5, 1'b0, 2'b11);
    fork
      send_frame(0, 9'h0A5, 1'b0, 2'b11);
      begin
        for (int t = 0; t < 14 * CPB && !found; t++) begin
          @(negedge clk);
          if (if0.o_rx_dv === 1'b1) found = 1'b1;
        end
        while (found && if0.o_busy === 1'b1 && lat < 6) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    idle(CPB);
    compared++;
    if (!found || lat > 2) begin
      mismatched++;
      $display("FAIL basic_busy_fall: strobe_seen=%0d busy_fall_cycles=%0d expected strobe and <=2", found, lat);
    end
    compared++;
    if (qsize(0) != 1) begin
      mismatched++;
      $display("FAIL basic_strobe_count: got %0d expected 1", qsize(0));
    end
    while (qsize(0) > 0) begin
      r = pop_rec(0);
      compared++;
      if (r !== e) begin
        mismatched++;
        $display("FAIL basic_frame: got %h expected %h", r, e);
      end else $display("rx0 frame: data=%h perr=%b ferr=%b brk=%b", r.data, r.perr, r.ferr, r.brk);
    end
  endtask

  task automatic test_glitch;
    snap_t s;
    line[0] = 1'b0;
    idle(4);
    line[0] = 1'b1;
    idle(3 * CPB);
    s = snap(0);
    compared++;
    if (qsize(0) != 0) begin
      mismatched++;
      $display("FAIL glitch_strobe_count: got %0d expected 0", qsize(0));
    end
    compared++;
    if (s.data !== 9'h0A5 || s.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch_hold: data=%h busy=%b expected data=0a5 busy=0", s.data, s.busy);
    end else $display("rx0 glitch: ignored, data held %h", s.data);
  endtask

  task automatic test_parity;
    rec_t r, e;
    for (int p = 1; p >= 0; p--) begin
      e = model(1, 9'h03C, 1'(p), 2'b11);
      send_frame(1, 9'h03C, 1'(p), 2'b11);
      idle(CPB);
      compared++;
      if (qsize(1) != 1) begin
        mismatched++;
        $display("FAIL parity_strobe_count: got %0d expected 1", qsize(1));
      end
      while (qsize(1) > 0) begin
        r = pop_rec(1);
        compared++;
        if (r !== e || r.perr !== 1'(p)) begin
          mismatched++;
          $display("FAIL parity_frame(pbit=%0d): got %h expected %h", p, r, e);
        end else $display("rx1 frame: data=%h perr=%b ferr=%b brk=%b", r.data, r.perr, r.ferr, r.brk);
      end
    end
  endtask

  task automatic test_stop2_break;
    rec_t r, e;
    e = model(2, 9'h081, 1'b0, 2'b01);
    send_frame(2, 9'h081, 1'b0, 2'b01);
    idle(CPB);
    compared++;
    if (qsize(2) != 1) begin
      mismatched++;
      $display("FAIL stop2_strobe_count: got %0d expected 1", qsize(2));
    end
    while (qsize(2) > 0) begin
      r = pop_rec(2);
      compared++;
      if (r !== e || r.ferr !== 1'b1 || r.brk !== 1'b0) begin
        mismatched++;
        $display("FAIL stop2_frame: got %h expected %h", r, e);
      end else $display("rx2 frame: data=%h perr=%b ferr=%b brk=%b", r.data, r.perr, r.ferr, r.brk);
    end
    // Line held low for 12 bit times: one break frame, no re-framing until the line recovers
    line[2] = 1'b0;
    idle(12 * CPB);
    line[2] = 1'b1;
    idle(4 * CPB);
    e = '{data: 9'h000, perr: 1'b0, ferr: 1'b1, brk: 1'b1};
    compared++;
    if (qsize(2) != 1) begin
      mismatched++;
      $display("FAIL break_strobe_count: got %0d expected 1", qsize(2));
    end
    while (qsize(2) > 0) begin
      r = pop_rec(2);
      compared++;
      if (r !== e) begin
        mismatched++;
        $display("FAIL break_frame: got %h expected %h", r, e);
      end else $display("rx2 break: data=%h perr=%b ferr=%b brk=%b", r.data, r.perr, r.ferr, r.brk);
    end
    e = model(2, 9'h03E, 1'b0, 2'b11);
    send_frame(2, 9'h03E, 1'b0, 2'b11);
    idle(CPB);
    compared++;
    if (qsize(2) != 1) begin
      mismatched++;
      $display("FAIL break_recover_count: got %0d expected 1", qsize(2));
    end
    while (qsize(2) > 0) begin
      r = pop_rec(2);
      compared++;
      if (r !== e) begin
        mismatched++;
        $display("FAIL break_recover_frame: got %h expected %h", r, e);
      end else $display("rx2 frame: data=%h perr=%b ferr=%b brk=%b", r.data, r.perr, r.ferr, r.brk);
    end
  endtask

  task automatic test_back_to_back;
    rec_t r;
    rec_t e [2];
    e[0] = model(3, 9'h055, good_parity(3, 9'h055), 2'b11);
    e[1] = model(3, 9'h02A, good_parity(3, 9'h02A), 2'b11);
    send_frame(3, 9'h055, good_parity(3, 9'h055), 2'b11);
    send_frame(3, 9'h02A, good_parity(3, 9'h02A), 2'b11);
    idle(CPB);
    compared++;
    if (qsize(3) != 2) begin
      mismatched++;
      $display("FAIL b2b_strobe_count: got %0d expected 2", qsize(3));
    end
    for (int i = 0; i < 2 && qsize(3) > 0; i++) begin
      r = pop_rec(3);
      compared++;
      if (r !== e[i] || r.perr !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_frame%0d: got %h expected %h", i, r, e[i]);
      end else $display("rx3 frame: data=%h perr=%b ferr=%b brk=%b", r.data, r.perr, r.ferr, r.brk);
    end
  endtask

  task automatic test_reset_mid;
    snap_t s;
    rec_t  r, e;
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    line[0] = 1'b1;
    idle(CPB / 2);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      s = snap(k);
      compared++;
      if (s !== '0) begin
        mismatched++;
        $display("FAIL async_reset[%0d]: got %h expected 0", k, s);
      end else $display("reset_mid[%0d]: outputs cleared", k);
    end
    idle(2 * CPB);
    rst = 1'b0;
    idle(CPB);
    e = model(0, 9'h05A, 1'b0, 2'b11);
    send_frame(0, 9'h05A, 1'b0, 2'b11);
    idle(CPB);
    compared++;
    if (qsize(0) != 1) begin
      mismatched++;
      $display("FAIL reset_recover_count: got %0d expected 1", qsize(0));
    end
    while (qsize(0) > 0) begin
      r = pop_rec(0);
      compared++;
      if (r !== e) begin
        mismatched++;
        $display("FAIL reset_recover_frame: got %h expected %h", r, e);
      end else $display("rx0 frame: data=%h perr=%b ferr=%b brk=%b", r.data, r.perr, r.ferr, r.brk);
    end
  endtask

  task automatic test_random;
    rec_t       exp_q[$];
    rec_t       r, e;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;
    for (int k = 0; k < 4; k++) begin
      exp_q.delete();
      while (qsize(k) > 0) r = pop_rec(k);
      for (int n = 0; n < 12; n++) begin
        data  = 9'($urandom);
        if ($urandom_range(0, 9) == 0) data = 9'd0;
        pbit  = good_parity(k, data) ^ ($urandom_range(0, 3) == 0);
        stops = 2'b11;
        if ($urandom_range(0, 4) == 0) stops = 2'($urandom_range(0, 2));
        e = model(k, data, pbit, stops);
        exp_q.push_back(e);
        send_frame(k, data, pbit, stops);
        if (e.ferr) idle(CPB + $urandom_range(0, CPB));
        else        idle($urandom_range(0, CPB));
      end
      idle(2 * CPB);
      compared++;
      if (qsize(k) != exp_q.size()) begin
        mismatched++;
        $display("FAIL random_count[%0d]: got %0d expected %0d", k, qsize(k), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && qsize(k) > 0; i++) begin
        r = pop_rec(k);
        compared++;
        if (r !== exp_q[i]) begin
          mismatched++;
          $display("FAIL random_frame[%0d][%0d]: got %h expected %h", k, i, r, exp_q[i]);
        end else $display("rx%0d random %0d: data=%h perr=%b ferr=%b brk=%b",
                          k, i, r.data, r.perr, r.ferr, r.brk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_stop2_break();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
